// File: rtl/encoder_scan.sv
// Multi-hot to index serializer: accepts one request vector and streams the
// index of every set bit, lowest first, over a valid/ready output.
module encoder_scan #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] Z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] A,
  output logic         out_last,
  output logic         zero_seen
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [W-1:0] low_idx;
  logic         one_left;
  logic         accept;
  logic         beat;

  // Priority search from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = W'(i);
    end
  end

  assign one_left  = (pending != '0) && ((pending & (pending - ONE)) == '0);

  // Outputs decode registered state only; no input reaches an output.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SCAN);
  assign A         = out_valid ? low_idx : '0;
  assign out_last  = out_valid && one_left;

  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_seen <= 1'b0;
    end else begin
      zero_seen <= accept && (Z == '0);
      case (state)
        IDLE: begin
          if (accept && (Z != '0)) begin
            pending <= Z;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (beat) begin
            // Clearing the lowest set bit retires exactly the index on A.
            pending <= pending & (pending - ONE);
            if (one_left) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
